// File: rtl/spi_listener_pkg.sv
// ----------------------------------------------------------------------------
// spi_listener_pkg
// Shared definitions for the SPI listener slice: default frame width, FSM
// state encoding and the idle line levels the pin synchronizers reset to.
// ----------------------------------------------------------------------------
package spi_listener_pkg;

  // Default number of bits in one SPI frame.
  localparam int SPI_FRAME_BITS = 24;

  // Listener FSM: IDLE while chip select is high, ACTIVE while a frame runs.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Idle line levels of the synchronized pins, bit order {mosi, cs_n, sclk}.
  localparam logic [2:0] SYNC_RESET_LEVELS = 3'b010;

endpackage

// File: rtl/spi_listener_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for one asynchronous input bit. Both flops reset to
// RESET_VAL so the synchronized output shows the idle line level while in
// reset.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   d      asynchronous input
//   q      input synchronized to clk (two cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/spi_listener.sv
// ----------------------------------------------------------------------------
// spi_listener
// Mode-0 SPI slave oversampled by the system clock. Receives DATA_WIDTH-bit
// frames MSB first on spi_mosi, returns tx_data (captured at frame start) on
// spi_miso, and reports each complete frame through fpga_spi_data plus a
// level interrupt. Short or long frames raise a one-cycle frame_error.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi      SPI pins from the external master (asynchronous)
//   spi_miso, spi_miso_oe   serial response and its drive enable
//   tx_data                 response word, sampled when a frame starts
//   fpga_spi_data           last complete received word
//   spi_listener_interrupt  new-word flag, cleared by int_clear
//   int_clear               one-cycle clear for interrupt and overrun
//   overrun                 a frame completed while the interrupt was pending
//   frame_error             one-cycle pulse on a frame of the wrong length
// ----------------------------------------------------------------------------
module spi_listener
  import spi_listener_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] fpga_spi_data,
  output logic                  spi_listener_interrupt,
  input  logic                  int_clear,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

  // ---------------- pin synchronizers ----------------
  logic [2:0] pin_raw;
  logic [2:0] pin_sync;

  assign pin_raw = {spi_mosi, spi_cs_n, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      sync_2ff #(
        .RESET_VAL (SYNC_RESET_LEVELS[gi])
      ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_raw[gi]),
        .q     (pin_sync[gi])
      );
    end
  endgenerate

  // ---------------- edge detection ----------------
  // Edge pulses are registered; mosi is delayed by the same stage so the
  // sample taken on a sclk rise pulse is the value present at that rise.
  logic sclk_d_reg, cs_d_reg, mosi_d_reg;
  logic sclk_rise_reg, sclk_fall_reg, cs_rise_reg, cs_fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b1;
      mosi_d_reg    <= 1'b0;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      cs_rise_reg   <= 1'b0;
      cs_fall_reg   <= 1'b0;
    end else begin
      sclk_d_reg    <= pin_sync[0];
      cs_d_reg      <= pin_sync[1];
      mosi_d_reg    <= pin_sync[2];
      sclk_rise_reg <=  pin_sync[0] & ~sclk_d_reg;
      sclk_fall_reg <= ~pin_sync[0] &  sclk_d_reg;
      cs_rise_reg   <=  pin_sync[1] & ~cs_d_reg;
      cs_fall_reg   <= ~pin_sync[1] &  cs_d_reg;
    end
  end

  // ---------------- arming after reset ----------------
  // The synchronizers come out of reset showing cs_n high, so a select that
  // was already low at reset release looks like a fresh fall. Frames are
  // only accepted once the pipeline has flushed and cs_n was seen high.
  logic [1:0] settle_cnt_reg;
  logic       armed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_reg <= 2'd0;
      armed_reg      <= 1'b0;
    end else if (settle_cnt_reg != 2'd3) begin
      settle_cnt_reg <= settle_cnt_reg + 2'd1;
    end else if (cs_d_reg) begin
      armed_reg <= 1'b1;
    end
  end

  // ---------------- listener FSM ----------------
  state_t                state_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] rx_shift_reg;
  logic [DATA_WIDTH-1:0] tx_shift_reg;
  logic                  miso_reg;
  logic                  miso_oe_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  irq_reg;
  logic                  overrun_reg;
  logic                  frame_error_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      miso_reg        <= 1'b0;
      miso_oe_reg     <= 1'b0;
      data_reg        <= '0;
      irq_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      frame_error_reg <= 1'b0;
      if (int_clear) begin
        irq_reg     <= 1'b0;
        overrun_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall_reg && armed_reg) begin
            state_reg    <= ACTIVE;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= tx_data;
            miso_reg     <= tx_data[DATA_WIDTH-1];
            miso_oe_reg  <= 1'b1;
          end
        end

        ACTIVE: begin
          if (cs_rise_reg) begin
            state_reg   <= IDLE;
            miso_reg    <= 1'b0;
            miso_oe_reg <= 1'b0;
            if (bit_cnt_reg == CNT_FULL) begin
              // A completing frame beats a simultaneous int_clear.
              data_reg    <= rx_shift_reg;
              irq_reg     <= 1'b1;
              overrun_reg <= ~int_clear & (overrun_reg | irq_reg);
            end else if (bit_cnt_reg != '0) begin
              frame_error_reg <= 1'b1;
            end
          end else if (sclk_rise_reg) begin
            rx_shift_reg <= {rx_shift_reg[DATA_WIDTH-2:0], mosi_d_reg};
            if (bit_cnt_reg != CNT_SAT) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (sclk_fall_reg) begin
            // Zeros shift in behind the word, so miso idles low once the
            // whole response has gone out.
            tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
            miso_reg     <= tx_shift_reg[DATA_WIDTH-2];
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_miso               = miso_reg;
  assign spi_miso_oe            = miso_oe_reg;
  assign fpga_spi_data          = data_reg;
  assign spi_listener_interrupt = irq_reg;
  assign overrun                = overrun_reg;
  assign frame_error            = frame_error_reg;

endmodule

// File: tb/tb_spi_listener.sv
// ----------------------------------------------------------------------------
// tb_spi_listener
// Drives SPI mode-0 frames into spi_listener. Each frame end pushes the event
// it should cause (word or frame error, with its due cycle) onto a
// scoreboard; a monitor pops and compares when the DUT reports something.
// ----------------------------------------------------------------------------
module tb_spi_listener;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          spi_sclk, spi_cs_n, spi_mosi;
  logic          spi_miso, spi_miso_oe;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] fpga_spi_data;
  logic          spi_listener_interrupt;
  logic          int_clear;
  logic          overrun;
  logic          frame_error;

  int vec_cnt     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int txn_cnt     = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          due_cyc;
  } exp_t;

  exp_t sb_q[$];

  spi_listener #(.DATA_WIDTH(DW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .spi_sclk               (spi_sclk),
    .spi_cs_n               (spi_cs_n),
    .spi_mosi               (spi_mosi),
    .spi_miso               (spi_miso),
    .spi_miso_oe            (spi_miso_oe),
    .tx_data                (tx_data),
    .fpga_spi_data          (fpga_spi_data),
    .spi_listener_interrupt (spi_listener_interrupt),
    .int_clear              (int_clear),
    .overrun                (overrun),
    .frame_error            (frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  // Shifts out nbits of word MSB first; collects miso at each sclk rise.
  task automatic spi_bits(input logic [31:0] word, input int nbits,
                          output logic [31:0] miso_word, output logic oe_all);
    miso_word = '0;
    oe_all    = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = word[i];
      wait_clk(8);
      spi_sclk  = 1'b1;
      miso_word = {miso_word[30:0], spi_miso};
      oe_all    = oe_all & spi_miso_oe;
      wait_clk(8);
      spi_sclk = 1'b0;
    end
  endtask

  // kind: 0 = no event expected, 1 = word, 2 = frame error.
  task automatic spi_end(input int kind, input logic [31:0] data, input bit clr_at_end);
    exp_t e;
    wait_clk(8);
    spi_cs_n = 1'b1;
    if (kind != 0) begin
      e.is_err  = (kind == 2);
      e.data    = data;
      e.due_cyc = cyc + 4;
      sb_q.push_back(e);
    end
    if (clr_at_end) begin
      wait_clk(3);
      int_clear = 1'b1;
      wait_clk(1);
      int_clear = 1'b0;
      wait_clk(12);
    end else begin
      wait_clk(16);
    end
  endtask

  task automatic spi_frame(input logic [31:0] word, input bit clr_at_end);
    logic [31:0] mw;
    logic        oe;
    spi_begin();
    spi_bits(word, DW, mw, oe);
    spi_end(1, word, clr_at_end);
  endtask

  task automatic pulse_clear();
    int_clear = 1'b1;
    wait_clk(1);
    int_clear = 1'b0;
    wait_clk(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"},    {31'd0, spi_miso}, 32'd0);
    check({tag, "_oe"},      {31'd0, spi_miso_oe}, 32'd0);
    check({tag, "_data"},    {8'd0, fpga_spi_data}, 32'd0);
    check({tag, "_irq"},     {31'd0, spi_listener_interrupt}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_ferr"},    {31'd0, frame_error}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] prev_data;
  logic          prev_irq;
  logic          prev_ferr;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_data = fpga_spi_data;
      prev_irq  = spi_listener_interrupt;
      prev_ferr = frame_error;
    end else begin
      if (prev_ferr) check("ferr_width", {31'd0, frame_error}, 32'd0);
      if (frame_error || (fpga_spi_data != prev_data) ||
          (spi_listener_interrupt && !prev_irq)) begin
        txn_cnt++;
        $display("txn %0d: %s data=%h irq=%0b ovr=%0b at cycle %0d", txn_cnt,
                 frame_error ? "frame_error" : "word", fpga_spi_data,
                 spi_listener_interrupt, overrun, cyc);
        check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("evt_kind", {31'd0, frame_error}, {31'd0, e.is_err});
          check("evt_latency", 32'(cyc), 32'(e.due_cyc));
          if (!e.is_err) begin
            check("evt_data", {8'd0, fpga_spi_data}, e.data);
            check("evt_irq", {31'd0, spi_listener_interrupt}, 32'd1);
          end
        end
      end
      prev_data = fpga_spi_data;
      prev_irq  = spi_listener_interrupt;
      prev_ferr = frame_error;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] miso_w;
    logic        oe_ok;

    rst_n     = 1'b0;
    spi_sclk  = 1'b0;
    spi_cs_n  = 1'b1;
    spi_mosi  = 1'b0;
    int_clear = 1'b0;
    tx_data   = 24'hA5A5A5;
    wait_clk(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(10);

    // Full frame with response word.
    spi_begin();
    spi_bits(32'h1F8093, DW, miso_w, oe_ok);
    check("miso_word", miso_w, 32'hA5A5A5);
    check("miso_oe", {31'd0, oe_ok}, 32'd1);
    spi_end(1, 32'h1F8093, 1'b0);
    check("t1_irq", {31'd0, spi_listener_interrupt}, 32'd1);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    check("t1_miso_idle", {31'd0, spi_miso}, 32'd0);
    pulse_clear();
    check("t1_irq_clr", {31'd0, spi_listener_interrupt}, 32'd0);

    // Short frame.
    spi_begin();
    spi_bits(32'hABC, 12, miso_w, oe_ok);
    spi_end(2, 32'd0, 1'b0);
    check("t2_data", {8'd0, fpga_spi_data}, 32'h1F8093);
    check("t2_irq", {31'd0, spi_listener_interrupt}, 32'd0);

    // Overrun.
    spi_frame(32'h000001, 1'b0);
    spi_frame(32'h000002, 1'b0);
    check("t3_data", {8'd0, fpga_spi_data}, 32'h000002);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    pulse_clear();
    check("t3_irq_clr", {31'd0, spi_listener_interrupt}, 32'd0);
    check("t3_ovr_clr", {31'd0, overrun}, 32'd0);

    // Clear coinciding with completion while the interrupt is pending.
    spi_frame(32'h0A0B0C, 1'b0);
    spi_frame(32'h123456, 1'b1);
    check("t4_irq", {31'd0, spi_listener_interrupt}, 32'd1);
    check("t4_overrun", {31'd0, overrun}, 32'd0);
    check("t4_data", {8'd0, fpga_spi_data}, 32'h123456);
    pulse_clear();

    // Reset in the middle of a frame.
    spi_begin();
    spi_bits(32'hABCDEF >> 14, 10, miso_w, oe_ok);
    rst_n = 1'b0;
    wait_clk(2);
    check_all_zero("midrst");
    rst_n = 1'b1;
    spi_bits(32'hABCDEF & 32'h3FFF, 14, miso_w, oe_ok);
    spi_end(0, 32'd0, 1'b0);
    check("t5_irq", {31'd0, spi_listener_interrupt}, 32'd0);
    check("t5_data", {8'd0, fpga_spi_data}, 32'd0);
    spi_frame(32'hABCDEF, 1'b0);
    check("t5_rx_irq", {31'd0, spi_listener_interrupt}, 32'd1);
    check("t5_rx_data", {8'd0, fpga_spi_data}, 32'hABCDEF);

    wait_clk(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
